// File: rtl/vedic_mac_accumulator.sv
// vedic_mac_accumulator: sums unsigned 8-bit product terms into a 16-bit
// accumulator, then serializes the result low byte first, high byte second.
// A sum is flushed on a prod_last term or after MAX_TERMS terms.
// Optional build macro VEDIC_MAC_SATURATE_EN: clamp acc at 0xFFFF on overflow
// instead of wrapping. The ovf flag behaves the same in both builds.
module vedic_mac_accumulator #(
    parameter int MAX_TERMS = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] prod,
    input  logic       prod_valid,
    input  logic       prod_last,
    output logic       prod_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ovf
);

    typedef enum logic [1:0] {ACCUM, SEND_LO, SEND_HI} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_TERMS);

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        prod_ready_q, prod_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [16:0] sum_ext;
    logic        accept;

    // Next-state and next-output computation; all outputs are registered
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sum_ext     = {1'b0, acc_q} + {9'b0, prod};
        accept      = prod_valid & prod_ready_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + 8'd1;
                    ovf_d = ovf_q | sum_ext[16];
`ifdef VEDIC_MAC_SATURATE_EN
                    acc_d = sum_ext[16] ? 16'hFFFF : sum_ext[15:0];
`else
                    acc_d = sum_ext[15:0];
`endif
                    // The flushing term is already folded into acc_d here
                    if (prod_last || cnt_d == MAX_CNT) begin
                        state_d     = SEND_LO;
                        out_valid_d = 1'b1;
                        out_data_d  = acc_d[7:0];
                    end
                end
            end
            SEND_LO: begin
                if (out_ready) begin
                    state_d    = SEND_HI;
                    out_data_d = acc_q[15:8];
                end
            end
            SEND_HI: begin
                if (out_ready) begin
                    state_d     = ACCUM;
                    acc_d       = 16'h0000;
                    cnt_d       = 8'd0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    out_data_d  = 8'h00;
                end
            end
            default: begin
                state_d     = ACCUM;
                out_valid_d = 1'b0;
                out_data_d  = 8'h00;
            end
        endcase

        // Ready follows the state being entered so it is a clean flop output
        prod_ready_d = (state_d == ACCUM);
    end

    // State and output registers; reset clears everything including ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            acc_q        <= 16'h0000;
            cnt_q        <= 8'd0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign ovf        = ovf_q;

endmodule
